// File: rtl/pcileech_tlp_tx_assemble.sv
// Buffers tagged host-to-device TLP DWORDs in block RAM and replays each
// complete, validated TLP gap-free onto the 32-bit TRN transmit port.
module pcileech_tlp_tx_assemble #(
  parameter int BUF_AW     = 9,
  parameter int MAX_TLP_DW = 132,
  parameter int LEN_AW     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] tlp_rx_data,
  input  logic        tlp_rx_valid,
  output logic        tlp_rx_ready,
  input  logic        cfg_bus_master_en,
  input  logic        trn_lnk_up_n,
  output logic [31:0] trn_td,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n,
  output logic [15:0] stat_drop_cnt
);
  localparam int LW = $clog2(MAX_TLP_DW + 1);
  localparam int PW = BUF_AW + 1;

  typedef enum logic [1:0] {IDLE, PREP, SEND} tx_state_e;

  logic [31:0]   buf_mem [2**BUF_AW];
  logic [LW-1:0] len_mem [2**LEN_AW];
  logic [31:0]   rd_dout_q;
  logic [BUF_AW-1:0] rd_addr;

  logic [PW-1:0]   wr_tmp_q, wr_commit_q, rd_ptr_q, used;
  logic [LW-1:0]   len_q, tx_len_q, cur_q;
  logic            ovf_q, rx_ready_q;
  logic [LEN_AW:0] lf_wp_q, lf_rp_q, lf_cnt;
  logic            lf_empty;
  logic [15:0]     drop_cnt_q;
  tx_state_e       state_q;
  logic [31:0]     td_q;
  logic            sof_n_q, eof_n_q, srdy_n_q;

  logic lnk_down, acc, last, short_tlp, commit, drop, wr_en, ready_d, hs;
  logic unused_rx_bits;

  assign unused_rx_bits = ^tlp_rx_data[31:11];
  assign lnk_down  = trn_lnk_up_n;
  assign acc       = tlp_rx_valid && tlp_rx_data[7:0] == 8'h77 &&
                     tlp_rx_data[9:8] == 2'b11 && !lnk_down;
  assign last      = tlp_rx_data[10];
  assign short_tlp = len_q < LW'(2);
  assign commit    = acc && !ovf_q && last && !short_tlp && cfg_bus_master_en;
  assign drop      = acc && last && (ovf_q || short_tlp || !cfg_bus_master_en);
  assign wr_en     = acc && !ovf_q && !RESET;

  assign lf_cnt   = lf_wp_q - lf_rp_q;
  assign lf_empty = lf_cnt == '0;
  assign used     = wr_tmp_q - rd_ptr_q;
  // 4-DWORD margin absorbs words already requested under a registered ready
  assign ready_d  = used <= PW'(2**BUF_AW - 4) &&
                    lf_cnt < (LEN_AW+1)'(2**LEN_AW - 1);
  assign hs       = state_q == SEND && !srdy_n_q && !trn_tdst_rdy_n;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_tmp_q    <= '0;
      wr_commit_q <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      lf_wp_q     <= '0;
      rx_ready_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else if (lnk_down) begin
      wr_commit_q <= wr_tmp_q;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      lf_wp_q     <= '0;
      rx_ready_q  <= 1'b1;
    end else begin
      rx_ready_q <= ready_d;
      if (acc) begin
        if (!last) begin
          if (!ovf_q) begin
            wr_tmp_q <= wr_tmp_q + PW'(1);
            len_q    <= len_q + LW'(1);
            ovf_q    <= len_q == LW'(MAX_TLP_DW - 1);
          end
        end else if (commit) begin
          wr_tmp_q    <= wr_tmp_q + PW'(1);
          wr_commit_q <= wr_tmp_q + PW'(1);
          len_q       <= '0;
          lf_wp_q     <= lf_wp_q + 1'b1;
        end else begin
          wr_tmp_q <= wr_commit_q;
          len_q    <= '0;
          ovf_q    <= 1'b0;
        end
      end
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) buf_mem[wr_tmp_q[BUF_AW-1:0]] <= tlp_rx_data[63:32];
    rd_dout_q <= buf_mem[rd_addr];
  end

  always_ff @(posedge CLK)
    if (commit && !RESET) len_mem[lf_wp_q[LEN_AW-1:0]] <= len_q + LW'(1);

  // BRAM output register doubles as the prefetch stage: its address only
  // moves past the next DWORD when the current one is handed off
  always_comb begin
    rd_addr = rd_ptr_q[BUF_AW-1:0];
    case (state_q)
      PREP: rd_addr = BUF_AW'(rd_ptr_q + PW'(1));
      SEND: begin
        if (hs && !eof_n_q) rd_addr = BUF_AW'(rd_ptr_q + PW'(tx_len_q));
        else rd_addr = BUF_AW'(rd_ptr_q + PW'(cur_q) + (hs ? PW'(2) : PW'(1)));
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      lf_rp_q  <= '0;
      tx_len_q <= '0;
      cur_q    <= '0;
      td_q     <= '0;
      sof_n_q  <= 1'b1;
      eof_n_q  <= 1'b1;
      srdy_n_q <= 1'b1;
    end else if (lnk_down) begin
      state_q  <= IDLE;
      rd_ptr_q <= wr_tmp_q;
      lf_rp_q  <= '0;
      sof_n_q  <= 1'b1;
      eof_n_q  <= 1'b1;
      srdy_n_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (!lf_empty) begin
          tx_len_q <= len_mem[lf_rp_q[LEN_AW-1:0]];
          lf_rp_q  <= lf_rp_q + 1'b1;
          state_q  <= PREP;
        end
        PREP: begin
          td_q     <= rd_dout_q;
          cur_q    <= '0;
          srdy_n_q <= 1'b0;
          sof_n_q  <= 1'b0;
          eof_n_q  <= tx_len_q != LW'(1);
          state_q  <= SEND;
        end
        SEND: if (hs) begin
          if (!eof_n_q) begin
            rd_ptr_q <= rd_ptr_q + PW'(tx_len_q);
            srdy_n_q <= 1'b1;
            sof_n_q  <= 1'b1;
            eof_n_q  <= 1'b1;
            // chain straight into the next TLP to keep the gap at 2 cycles
            if (!lf_empty) begin
              tx_len_q <= len_mem[lf_rp_q[LEN_AW-1:0]];
              lf_rp_q  <= lf_rp_q + 1'b1;
              state_q  <= PREP;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            td_q    <= rd_dout_q;
            cur_q   <= cur_q + LW'(1);
            sof_n_q <= 1'b1;
            eof_n_q <= (cur_q + LW'(2)) != tx_len_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tlp_rx_ready   = rx_ready_q;
  assign trn_td         = td_q;
  assign trn_tsof_n     = sof_n_q;
  assign trn_teof_n     = eof_n_q;
  assign trn_tsrc_rdy_n = srdy_n_q;
  assign trn_tsrc_dsc_n = 1'b1;
  assign stat_drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_pcileech_tlp_tx_assemble.sv
// Scoreboard bench: upstream FIFO model feeds tagged words, TRN beats are
// popped against expected {sof_n, eof_n, td} entries.
module tb_pcileech_tlp_tx_assemble;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [63:0] tlp_rx_data = '0;
  logic        tlp_rx_valid = 1'b0;
  logic        tlp_rx_ready;
  logic        cfg_bus_master_en = 1'b1;
  logic        trn_lnk_up_n = 1'b0;
  logic [31:0] trn_td;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n = 1'b1;
  logic [15:0] stat_drop_cnt;

  int total = 0, bad = 0, cyc = 0, exp_drop = 0;
  int last_cyc = 0, sof_cyc = 0, eof_cyc = -100, sof_gap = 0;
  bit saw_throttle = 1'b0;
  logic [63:0] in_q[$];
  logic [33:0] exp_q[$];

  pcileech_tlp_tx_assemble dut (
    .CLK(CLK), .RESET(RESET),
    .tlp_rx_data(tlp_rx_data), .tlp_rx_valid(tlp_rx_valid), .tlp_rx_ready(tlp_rx_ready),
    .cfg_bus_master_en(cfg_bus_master_en), .trn_lnk_up_n(trn_lnk_up_n),
    .trn_td(trn_td), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
    .trn_tdst_rdy_n(trn_tdst_rdy_n), .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkw(input logic [31:0] dw, input bit lst,
                                      input logic [7:0] mg, input logic [1:0] ty);
    return {dw, 21'd0, lst, ty, mg};
  endfunction

  task automatic push_tlp(input int n, input logic [31:0] base, input bit tx);
    for (int i = 0; i < n; i++) begin
      in_q.push_back(mkw(base + 32'(i), i == n - 1, 8'h77, 2'b11));
      if (tx) exp_q.push_back({i != 0, i != n - 1, base + 32'(i)});
    end
  endtask

  task automatic wait_done(input int maxc, input bit tog);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < maxc) begin
      @(posedge CLK); #1;
      if (tog) trn_tdst_rdy_n = ~trn_tdst_rdy_n;
      n++;
    end
    if (n >= maxc) begin
      chk("timeout", 64'(in_q.size() + exp_q.size()), 0);
      in_q.delete();
      exp_q.delete();
    end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic wait_srdy(input string tag);
    int n = 0;
    while (trn_tsrc_rdy_n && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) chk(tag, trn_tsrc_rdy_n, 0);
  endtask

  // upstream FIFO: a request seen during cycle c returns data in cycle c+1
  initial begin : drv
    bit rdy_s;
    forever begin
      @(negedge CLK);
      rdy_s = tlp_rx_ready;
      if (!rdy_s && in_q.size() > 0 && !RESET && !trn_lnk_up_n) saw_throttle = 1'b1;
      @(posedge CLK); #1;
      if (rdy_s && in_q.size() > 0) begin
        tlp_rx_data  = in_q.pop_front();
        tlp_rx_valid = 1'b1;
        if (tlp_rx_data[10] && tlp_rx_data[7:0] == 8'h77 && tlp_rx_data[9:8] == 2'b11)
          last_cyc = cyc;
      end else begin
        tlp_rx_valid = 1'b0;
      end
    end
  end

  initial begin : mon
    logic [34:0] prev;
    logic [33:0] e;
    bit prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge CLK);
      if (prev_stall)
        chk("stall_hold", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_td}, prev);
      prev = {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_td};
      prev_stall = !trn_tsrc_rdy_n && trn_tdst_rdy_n && !trn_lnk_up_n && !RESET;
      if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n && !RESET) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", {trn_tsof_n, trn_teof_n, trn_td}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {trn_tsof_n, trn_teof_n, trn_td}, e);
        end
        if (!trn_tsof_n) begin
          sof_gap = cyc - eof_cyc;
          sof_cyc = cyc;
        end
        if (!trn_teof_n) eof_cyc = cyc;
      end
    end
  end

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", tlp_rx_ready, 0);
    chk("rst_srdy", trn_tsrc_rdy_n, 1);
    chk("rst_sof", trn_tsof_n, 1);
    chk("rst_eof", trn_teof_n, 1);
    chk("rst_dsc", trn_tsrc_dsc_n, 1);
    chk("rst_td", trn_td, 0);
    chk("rst_drop", stat_drop_cnt, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    trn_tdst_rdy_n = 1'b0;

    // basic 4-DWORD TLP with latency and back-to-back beat checks
    push_tlp(4, 32'h1, 1'b1);
    wait_done(200, 1'b0);
    chk("t1_lat", 64'(sof_cyc - last_cyc), 3);
    chk("t1_span", 64'(eof_cyc - sof_cyc), 3);

    // same TLP under toggling backpressure
    push_tlp(4, 32'h1, 1'b1);
    wait_done(200, 1'b1);
    trn_tdst_rdy_n = 1'b0;

    // short, oversize, minimal-good TLPs; then exactly one over the limit
    push_tlp(2, 32'h10, 1'b0);
    push_tlp(140, 32'h1000, 1'b0);
    push_tlp(3, 32'h20, 1'b1);
    wait_done(1000, 1'b0);
    exp_drop = 2;
    chk("t3_drop", stat_drop_cnt, 64'(exp_drop));
    push_tlp(133, 32'h3000, 1'b0);
    wait_done(1000, 1'b0);
    exp_drop++;
    chk("t3_drop133", stat_drop_cnt, 64'(exp_drop));

    // bus master disabled at the last word
    cfg_bus_master_en = 1'b0;
    push_tlp(4, 32'h40, 1'b0);
    wait_done(200, 1'b0);
    exp_drop++;
    chk("t4_bme_drop", stat_drop_cnt, 64'(exp_drop));
    cfg_bus_master_en = 1'b1;
    push_tlp(4, 32'h50, 1'b1);
    wait_done(200, 1'b0);

    // two queued TLPs: next sof two cycles after eof handshake
    trn_tdst_rdy_n = 1'b1;
    push_tlp(4, 32'h100, 1'b1);
    push_tlp(4, 32'h200, 1'b1);
    repeat (30) @(posedge CLK);
    #1 trn_tdst_rdy_n = 1'b0;
    wait_done(200, 1'b0);
    chk("t5_gap", 64'(sof_gap), 2);

    // junk words (bad magic / bad type, some with last set) interleaved
    for (int i = 0; i < 5; i++) begin
      if (i > 0) in_q.push_back((i % 2) ? mkw(32'hBAD0 + 32'(i), 1'b1, 8'h76, 2'b11)
                                        : mkw(32'hBAD0 + 32'(i), 1'b1, 8'h77, 2'b00));
      in_q.push_back(mkw(32'hC000 + 32'(i), i == 4, 8'h77, 2'b11));
      exp_q.push_back({i != 0, i != 4, 32'hC000 + 32'(i)});
    end
    wait_done(300, 1'b0);
    chk("t6_drop", stat_drop_cnt, 64'(exp_drop));

    // bulk max-size TLPs against a long stall: throttling and pointer wrap
    saw_throttle = 1'b0;
    trn_tdst_rdy_n = 1'b1;
    for (int k = 0; k < 150; k++) push_tlp(132, 32'(k) << 16, 1'b1);
    repeat (2000) @(posedge CLK);
    #1;
    chk("t7_throttle", saw_throttle, 1);
    chk("t7_held", in_q.size() > 0, 1);
    trn_tdst_rdy_n = 1'b0;
    wait_done(40000, 1'b0);
    chk("t7_drop", stat_drop_cnt, 64'(exp_drop));

    // link drop mid-SEND flushes everything
    trn_tdst_rdy_n = 1'b1;
    push_tlp(8, 32'h7000, 1'b1);
    wait_srdy("t8_no_send");
    @(posedge CLK); #1;
    trn_lnk_up_n = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    chk("t8_srdy", trn_tsrc_rdy_n, 1);
    push_tlp(5, 32'h8000, 1'b0);
    wait_done(200, 1'b0);
    @(negedge CLK);
    chk("t8_ready", tlp_rx_ready, 1);
    @(posedge CLK); #1;
    trn_lnk_up_n = 1'b0;
    trn_tdst_rdy_n = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("t8_drop", stat_drop_cnt, 64'(exp_drop));
    push_tlp(4, 32'h9000, 1'b1);
    wait_done(200, 1'b0);

    // synchronous reset mid-packet
    trn_tdst_rdy_n = 1'b1;
    push_tlp(6, 32'hA000, 1'b1);
    wait_srdy("t9_no_send");
    @(posedge CLK); #1;
    RESET = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    chk("t9_srdy", trn_tsrc_rdy_n, 1);
    chk("t9_eof", trn_teof_n, 1);
    chk("t9_drop", stat_drop_cnt, 0);
    RESET = 1'b0;
    trn_tdst_rdy_n = 1'b0;
    push_tlp(3, 32'hB000, 1'b1);
    wait_done(200, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
